// File: rtl/fmrv32im_periph_bridge_pkg.sv
// Shared definitions for the fmrv32im peripheral register bus bridge:
// bus geometry, address-field positions, FSM state encoding, the latched
// request record and the byte-strobe mask helper.
package fmrv32im_periph_bridge_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned STRB_W   = DATA_W / 8;

  // Address fields: [31:12] window, [11:8] slot, [5:2] word index
  localparam int unsigned DEC_LSB  = 12;
  localparam int unsigned SLOT_LSB = 8;
  localparam int unsigned SLOT_W   = 4;
  localparam int unsigned IDX_LSB  = 2;
  localparam int unsigned IDX_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Request captured on acceptance; held for the whole transaction
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [SLOT_W-1:0] slot;
    logic              hit;
    logic [STRB_W-1:0] wstb;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Expand byte strobes into a per-bit lane mask
  function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] wstb);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      mask[i*8 +: 8] = {8{wstb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/fmrv32im_periph_bridge_if.sv
// Bundle of the CPU data-port handshake and the peripheral register bus.
//   master : the bridge (accepts CPU requests, drives the register bus)
//   slave  : the environment (CPU side drives the request, slaves drive read data)
// Signals:
//   mem_ena/mem_wstb/mem_addr/mem_wdata  CPU request (held until mem_wait=0)
//   mem_wait/mem_rdata/bus_err           CPU response
//   bus_we/bus_addr/bus_wdata            register bus command, one strobe per slot
//   bus_rdata                            per-slot read data, slot k on [32k+31:32k]
interface fmrv32im_periph_bridge_if #(
  parameter int unsigned NSLOTS = 4
);
  import fmrv32im_periph_bridge_pkg::*;

  logic                     mem_ena;
  logic [STRB_W-1:0]        mem_wstb;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_wait;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     bus_err;

  logic [NSLOTS-1:0]        bus_we;
  logic [IDX_W-1:0]         bus_addr;
  logic [DATA_W-1:0]        bus_wdata;
  logic [DATA_W*NSLOTS-1:0] bus_rdata;

  modport master (
    input  mem_ena, mem_wstb, mem_addr, mem_wdata, bus_rdata,
    output mem_wait, mem_rdata, bus_err, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output mem_ena, mem_wstb, mem_addr, mem_wdata, bus_rdata,
    input  mem_wait, mem_rdata, bus_err, bus_we, bus_addr, bus_wdata
  );

endinterface

// File: rtl/fmrv32im_periph_bridge_byte_merge.sv
// Byte-lane merge for read-modify-write: lanes with a set strobe come from
// new_word, the rest from old_word. Purely combinational.
//   old_word  in   32  current register contents
//   new_word  in   32  write data, lanes aligned to strobes
//   wstb      in   4   byte strobes
//   merged_c  out  32  merged word
module fmrv32im_periph_bridge_byte_merge
  import fmrv32im_periph_bridge_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [STRB_W-1:0] wstb,
  output logic [DATA_W-1:0] merged_c
);

  logic [DATA_W-1:0] mask_c;

  always_comb begin
    mask_c   = strb_mask(wstb);
    merged_c = (old_word & ~mask_c) | (new_word & mask_c);
  end

endmodule

// File: rtl/fmrv32im_periph_bridge.sv
// Initiator side of the peripheral register bus. Turns CPU data-port
// requests into single-cycle word accesses to NSLOTS slaves; sub-word
// writes are done as read-modify-write so slaves only ever see full words.
//   CLK    in  1  clock, all state on posedge
//   RST_N  in  1  synchronous reset, active low
//   bus    master modport of fmrv32im_periph_bridge_if (CPU port + register bus)
// Transaction flow: IDLE (accept) -> [RD] -> [WR] -> RESP -> IDLE.
module fmrv32im_periph_bridge
  import fmrv32im_periph_bridge_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned       NSLOTS    = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  fmrv32im_periph_bridge_if.master      bus
);

  state_e            state_q;
  req_t              req_q;
  req_t              req_c;
  logic [DATA_W-1:0] rd_mux_c;
  logic [DATA_W-1:0] merged_c;

  // Address bits that carry no meaning: byte offset and the aliased [7:6]
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.mem_addr[IDX_LSB-1:0],
                              bus.mem_addr[SLOT_LSB-1:IDX_LSB+IDX_W]};

  // One-hot slot strobe, all-zero on a decode miss
  function automatic logic [NSLOTS-1:0] slot_we(input logic hit,
                                                input logic [SLOT_W-1:0] slot);
    logic [NSLOTS-1:0] we;
    we = '0;
    for (int unsigned k = 0; k < NSLOTS; k++) begin
      we[k] = hit && (slot == SLOT_W'(k));
    end
    return we;
  endfunction

  // Decode the incoming request; a hit needs the window and an existing slot
  always_comb begin
    req_c.idx   = bus.mem_addr[IDX_LSB +: IDX_W];
    req_c.slot  = bus.mem_addr[SLOT_LSB +: SLOT_W];
    req_c.hit   = (bus.mem_addr[ADDR_W-1:DEC_LSB] == BASE_ADDR[ADDR_W-1:DEC_LSB]) &&
                  (32'(bus.mem_addr[SLOT_LSB +: SLOT_W]) < NSLOTS);
    req_c.wstb  = bus.mem_wstb;
    req_c.wdata = bus.mem_wdata;
  end

  // Read-data mux for the latched slot; a miss reads as zero
  always_comb begin
    rd_mux_c = '0;
    for (int unsigned k = 0; k < NSLOTS; k++) begin
      if (req_q.hit && (req_q.slot == SLOT_W'(k))) begin
        rd_mux_c = bus.bus_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Merge uses the slave value seen during RD, not a later one
  fmrv32im_periph_bridge_byte_merge u_merge (
    .old_word (rd_mux_c),
    .new_word (req_q.wdata),
    .wstb     (req_q.wstb),
    .merged_c (merged_c)
  );

  // Stall until the response cycle; only meaningful while a request is presented
  assign bus.mem_wait = bus.mem_ena && (state_q != ST_RESP);

  // Transaction FSM with registered bus and response outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      bus.bus_we    <= '0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.mem_rdata <= '0;
      bus.bus_err   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_ena) begin
            req_q         <= req_c;
            bus.bus_addr  <= req_c.idx;
            bus.bus_wdata <= req_c.wdata;
            if (req_c.wstb == '1) begin
              // Full-word write needs no read phase
              bus.bus_we <= slot_we(req_c.hit, req_c.slot);
              state_q    <= ST_WR;
            end else begin
              state_q    <= ST_RD;
            end
          end
        end

        ST_RD: begin
          if (req_q.wstb == '0) begin
            bus.mem_rdata <= rd_mux_c;
            bus.bus_err   <= !req_q.hit;
            state_q       <= ST_RESP;
          end else begin
            bus.bus_wdata <= merged_c;
            bus.bus_we    <= slot_we(req_q.hit, req_q.slot);
            state_q       <= ST_WR;
          end
        end

        ST_WR: begin
          bus.bus_we    <= '0;
          bus.mem_rdata <= '0;
          bus.bus_err   <= !req_q.hit;
          state_q       <= ST_RESP;
        end

        ST_RESP: begin
          bus.bus_addr  <= '0;
          bus.bus_wdata <= '0;
          bus.mem_rdata <= '0;
          bus.bus_err   <= 1'b0;
          state_q       <= ST_IDLE;
        end

        default: begin
          bus.bus_we <= '0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmrv32im_periph_bridge.sv
// Bench for fmrv32im_periph_bridge: register-file "timer" in slot 0, RAM
// in slot 1, constant-pattern slaves in slots 2 and 3.
module tb_fmrv32im_periph_bridge;

  logic CLK;
  logic RST_N;

  int n_checks;
  int n_fail;

  fmrv32im_periph_bridge_if #(.NSLOTS(4)) bus ();

  fmrv32im_periph_bridge #(
    .BASE_ADDR (32'h8000_0000),
    .NSLOTS    (4)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Slave models
  logic [31:0] t_regs [16];
  logic [31:0] ram    [16];

  always @(posedge CLK) begin
    if (bus.bus_we[0]) t_regs[bus.bus_addr] <= bus.bus_wdata;
    if (bus.bus_we[1]) ram[bus.bus_addr]    <= bus.bus_wdata;
  end

  assign bus.bus_rdata = {32'h3333_0000 + 32'(bus.bus_addr),
                          32'h2222_0000 + 32'(bus.bus_addr),
                          ram[bus.bus_addr],
                          t_regs[bus.bus_addr]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request at a negedge and follow it to its response cycle.
  // Returns at the negedge of the following IDLE cycle with ENA still high.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstb,
                         input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int ncyc, output int nwe,
                         output logic [3:0] we_seen, output logic [3:0] idx_seen,
                         output logic [31:0] bwd_seen);
    bit done;
    bus.mem_ena   = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wstb  = wstb;
    bus.mem_wdata = wdata;
    rdata = '0; err = 1'b0; ncyc = 0; nwe = 0;
    we_seen = '0; idx_seen = '0; bwd_seen = '0; done = 1'b0;
    while (!done && ncyc < 12) begin
      #1;
      ncyc++;
      if (ncyc == 2) idx_seen = bus.bus_addr;
      if (bus.bus_we != '0) begin
        nwe++;
        we_seen  = bus.bus_we;
        bwd_seen = bus.bus_wdata;
      end
      if (!bus.mem_wait) begin
        done  = 1'b1;
        rdata = bus.mem_rdata;
        err   = bus.bus_err;
      end
      @(negedge CLK);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL txn_timeout: addr %h never left wait", addr);
    end
  endtask

  // Drop ENA for one cycle and confirm the bus is back at rest
  task automatic idle_check(input string tag);
    bus.mem_ena = 1'b0;
    #1;
    check({tag, "_idle_err"},  32'(bus.bus_err),  32'd0);
    check({tag, "_idle_we"},   32'(bus.bus_we),   32'd0);
    check({tag, "_idle_addr"}, 32'(bus.bus_addr), 32'd0);
    check({tag, "_idle_wait"}, 32'(bus.mem_wait), 32'd0);
    @(negedge CLK);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
    int          exp_nwe;
    logic [3:0]  exp_we;
    logic [3:0]  exp_idx;
    logic [31:0] exp_bwd;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  logic [31:0] rdata, bwd;
  logic        err;
  int          ncyc, nwe, tot_we, rst_we;
  logic [3:0]  we_seen, idx_seen;

  initial begin
    //        addr          wstb   wdata          rdata          err  cyc nwe we     idx    bus_wdata
    vecs[0]  = '{32'h8000_0004, 4'hF, 32'h0000_0100, 32'h0,         1'b0, 3, 1, 4'b0001, 4'h1, 32'h0000_0100};
    vecs[1]  = '{32'h8000_0004, 4'h0, 32'h0,         32'h0000_0100, 1'b0, 3, 0, 4'b0000, 4'h1, 32'h0};
    vecs[2]  = '{32'h8000_010C, 4'hF, 32'hAABB_CCDD, 32'h0,         1'b0, 3, 1, 4'b0010, 4'h3, 32'hAABB_CCDD};
    vecs[3]  = '{32'h8000_010C, 4'h2, 32'h0000_1100, 32'h0,         1'b0, 4, 1, 4'b0010, 4'h3, 32'hAABB_11DD};
    vecs[4]  = '{32'h8000_010C, 4'h0, 32'h0,         32'hAABB_11DD, 1'b0, 3, 0, 4'b0000, 4'h3, 32'h0};
    vecs[5]  = '{32'h8000_010C, 4'h8, 32'h7700_0000, 32'h0,         1'b0, 4, 1, 4'b0010, 4'h3, 32'h77BB_11DD};
    vecs[6]  = '{32'h8000_010C, 4'h3, 32'h0000_5566, 32'h0,         1'b0, 4, 1, 4'b0010, 4'h3, 32'h77BB_5566};
    vecs[7]  = '{32'h8000_010C, 4'h0, 32'h0,         32'h77BB_5566, 1'b0, 3, 0, 4'b0000, 4'h3, 32'h0};
    vecs[8]  = '{32'h8000_00C4, 4'h0, 32'h0,         32'h0000_0100, 1'b0, 3, 0, 4'b0000, 4'h1, 32'h0};
    vecs[9]  = '{32'h8000_0208, 4'h0, 32'h0,         32'h2222_0002, 1'b0, 3, 0, 4'b0000, 4'h2, 32'h0};
    vecs[10] = '{32'h8000_033C, 4'h0, 32'h0,         32'h3333_000F, 1'b0, 3, 0, 4'b0000, 4'hF, 32'h0};
    vecs[11] = '{32'h8000_0500, 4'h0, 32'h0,         32'h0,         1'b1, 3, 0, 4'b0000, 4'h0, 32'h0};
    vecs[12] = '{32'h9000_0000, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b1, 3, 0, 4'b0000, 4'h0, 32'h0};
    vecs[13] = '{32'h8000_0F04, 4'h1, 32'h0000_0012, 32'h0,         1'b1, 4, 0, 4'b0000, 4'h1, 32'h0};
    vecs[14] = '{32'h8000_0004, 4'h0, 32'h0,         32'h0000_0100, 1'b0, 3, 0, 4'b0000, 4'h1, 32'h0};
    vecs[15] = '{32'h8000_010F, 4'h0, 32'h0,         32'h77BB_5566, 1'b0, 3, 0, 4'b0000, 4'h3, 32'h0};

    n_checks = 0;
    n_fail   = 0;
    RST_N         = 1'b0;
    bus.mem_ena   = 1'b0;
    bus.mem_wstb  = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    #1;
    check("rst_we",    32'(bus.bus_we),    32'd0);
    check("rst_addr",  32'(bus.bus_addr),  32'd0);
    check("rst_wdata", bus.bus_wdata,      32'd0);
    check("rst_rdata", bus.mem_rdata,      32'd0);
    check("rst_err",   32'(bus.bus_err),   32'd0);
    check("rst_wait",  32'(bus.mem_wait),  32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      run_txn(vecs[i].addr, vecs[i].wstb, vecs[i].wdata,
              rdata, err, ncyc, nwe, we_seen, idx_seen, bwd);
      check($sformatf("v%0d_rdata", i), rdata,                vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i),   32'(err),             32'(vecs[i].exp_err));
      check($sformatf("v%0d_cyc", i),   32'(ncyc),            32'(vecs[i].exp_cyc));
      check($sformatf("v%0d_nwe", i),   32'(nwe),             32'(vecs[i].exp_nwe));
      check($sformatf("v%0d_idx", i),   32'(idx_seen),        32'(vecs[i].exp_idx));
      if (vecs[i].exp_nwe > 0) begin
        check($sformatf("v%0d_we", i),  32'(we_seen),         32'(vecs[i].exp_we));
        check($sformatf("v%0d_bwd", i), bwd,                  vecs[i].exp_bwd);
      end
      idle_check($sformatf("v%0d", i));
    end
    check("timer_mask", t_regs[1], 32'h0000_0100);
    check("ram3_final", ram[3],    32'h77BB_5566);

    // Back-to-back read/write/read with ENA held throughout
    tot_we = 0;
    run_txn(32'h8000_0004, 4'h0, 32'h0, rdata, err, ncyc, nwe, we_seen, idx_seen, bwd);
    tot_we += nwe;
    check("b2b_rd1_data", rdata, 32'h0000_0100);
    check("b2b_rd1_cyc",  32'(ncyc), 32'd3);
    run_txn(32'h8000_0008, 4'hF, 32'h0000_0055, rdata, err, ncyc, nwe, we_seen, idx_seen, bwd);
    tot_we += nwe;
    check("b2b_wr_cyc",   32'(ncyc), 32'd3);
    check("b2b_wr_we",    32'(we_seen), 32'b0001);
    run_txn(32'h8000_0008, 4'h0, 32'h0, rdata, err, ncyc, nwe, we_seen, idx_seen, bwd);
    tot_we += nwe;
    check("b2b_rd2_data", rdata, 32'h0000_0055);
    check("b2b_rd2_cyc",  32'(ncyc), 32'd3);
    check("b2b_we_total", 32'(tot_we), 32'd1);
    idle_check("b2b");

    // ENA dropped right after acceptance: the write still completes
    bus.mem_ena   = 1'b1;
    bus.mem_addr  = 32'h8000_000C;
    bus.mem_wstb  = 4'hF;
    bus.mem_wdata = 32'h0000_0099;
    @(negedge CLK);
    bus.mem_ena = 1'b0;
    #1;
    check("drop_we",   32'(bus.bus_we),   32'b0001);
    check("drop_wait", 32'(bus.mem_wait), 32'd0);
    @(negedge CLK);
    #1;
    check("drop_resp_err", 32'(bus.bus_err), 32'd0);
    @(negedge CLK);
    run_txn(32'h8000_000C, 4'h0, 32'h0, rdata, err, ncyc, nwe, we_seen, idx_seen, bwd);
    check("drop_readback", rdata, 32'h0000_0099);
    idle_check("drop");

    // Reset at the edge that would start the WR phase of a partial write
    bus.mem_ena   = 1'b1;
    bus.mem_addr  = 32'h8000_010C;
    bus.mem_wstb  = 4'h1;
    bus.mem_wdata = 32'h0000_00FF;
    @(negedge CLK);
    #1;
    check("rst_mid_rd_addr", 32'(bus.bus_addr), 32'd3);
    RST_N  = 1'b0;
    rst_we = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      #1;
      if (bus.bus_we != '0) rst_we++;
    end
    check("rst_mid_no_we", 32'(rst_we),        32'd0);
    check("rst_mid_addr",  32'(bus.bus_addr),  32'd0);
    check("rst_mid_wdata", bus.bus_wdata,      32'd0);
    check("rst_mid_ram",   ram[3],             32'h77BB_5566);
    @(negedge CLK);
    RST_N = 1'b1;
    // ENA is still high: the request after release is taken as a fresh one
    run_txn(32'h8000_010C, 4'h0, 32'h0, rdata, err, ncyc, nwe, we_seen, idx_seen, bwd);
    check("rst_after_data", rdata, 32'h77BB_5566);
    check("rst_after_cyc",  32'(ncyc), 32'd3);
    check("rst_after_nwe",  32'(nwe),  32'd0);
    idle_check("rst_after");

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
